// File: rtl/fetch_queue_if.sv
// Fetch queue bundle: icache side (imemREN/imemaddr/ihit/imemload),
// control-flow inputs (redirect/redirect_pc/halt) and decode side
// (deq/inst_valid/inst/inst_pc/inst_npc/count).
//   master : the fetch queue unit
//   slave  : the surroundings (icache, control unit, decode)
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    logic                         ihit;
    logic [31:0]                  imemload;
    logic                         imemREN;
    logic [31:0]                  imemaddr;
    logic                         redirect;
    logic [31:0]                  redirect_pc;
    logic                         halt;
    logic                         deq;
    logic                         inst_valid;
    logic [31:0]                  inst;
    logic [31:0]                  inst_pc;
    logic [31:0]                  inst_npc;
    logic [$clog2(DEPTH+1)-1:0]   count;

    modport master (
        input  ihit, imemload, redirect, redirect_pc, halt, deq,
        output imemREN, imemaddr, inst_valid, inst, inst_pc, inst_npc, count
    );

    modport slave (
        output ihit, imemload, redirect, redirect_pc, halt, deq,
        input  imemREN, imemaddr, inst_valid, inst, inst_pc, inst_npc, count
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end. Owns the PC, requests sequential words from
// the icache and buffers returned instructions with their PC in a DEPTH-entry
// FIFO that decode drains with deq. A redirect flushes the queue and reloads
// the PC; halt stops fetching until reset while the queue still drains.
// Ports:
//   CLK   : clock, rising edge
//   nRST  : asynchronous active-low reset
//   fqif  : fetch_queue_if.master (icache, control-flow and decode signals)
//
// state   | meaning
// RUNNING | fetch requests allowed (subject to full/redirect/halt input)
// HALTED  | fetching off until nRST; queue still drains
module fetch_queue_unit #(
    parameter logic [31:0] PC_INIT = 32'h0,
    parameter int          DEPTH   = 4
) (
    input  logic          CLK,
    input  logic          nRST,
    fetch_queue_if.master fqif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {
        RUNNING = 1'b0,
        HALTED  = 1'b1
    } state_t;

    state_t          state, next_state;
    logic [31:0]     pc;
    logic [PW-1:0]   head, tail;
    logic [CW-1:0]   cnt;
    logic [31:0]     inst_q [DEPTH];
    logic [31:0]     pc_q   [DEPTH];
    logic            full, empty, push, pop, fetch_en;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= RUNNING;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        fetch_en   = 1'b0;
        case (state)
            RUNNING: begin
                fetch_en = ~fqif.halt;
                if (fqif.halt) next_state = HALTED;
            end
            HALTED: begin
                fetch_en = 1'b0;
            end
            default: next_state = RUNNING;
        endcase
    end

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);

    // Redirect suppresses the request, so push never coincides with a flush.
    assign fqif.imemREN  = fetch_en & ~fqif.redirect & ~full;
    assign fqif.imemaddr = pc;
    assign push          = fqif.imemREN & fqif.ihit;
    assign pop           = fqif.deq & ~empty;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc   <= PC_INIT;
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (fqif.redirect) begin
            pc   <= fqif.redirect_pc & ~32'h3;
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
                pc   <= pc + 32'd4;
            end
            if (pop) head <= head + PW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: count gates visibility of every entry.
    always_ff @(posedge CLK) begin
        if (push) begin
            inst_q[tail] <= fqif.imemload;
            pc_q[tail]   <= pc;
        end
    end

    assign fqif.inst_valid = ~empty;
    assign fqif.inst       = inst_q[head];
    assign fqif.inst_pc    = pc_q[head];
    assign fqif.inst_npc   = pc_q[head] + 32'd4;
    assign fqif.count      = cnt;
endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;
    logic CLK;
    logic nRST;
    int   total = 0;
    int   bad   = 0;

    fetch_queue_if #(.DEPTH(4)) f4 ();
    fetch_queue_if #(.DEPTH(2)) f2 ();

    fetch_queue_unit #(.PC_INIT(32'h0), .DEPTH(4)) dut4 (.CLK(CLK), .nRST(nRST), .fqif(f4));
    fetch_queue_unit #(.PC_INIT(32'h0), .DEPTH(2)) dut2 (.CLK(CLK), .nRST(nRST), .fqif(f2));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // icache contents: a word derived from its address
    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        f4.ihit = 0; f4.imemload = 0; f4.redirect = 0; f4.redirect_pc = 0; f4.halt = 0; f4.deq = 0;
        f2.ihit = 0; f2.imemload = 0; f2.redirect = 0; f2.redirect_pc = 0; f2.halt = 0; f2.deq = 0;
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        idle_inputs();
        nRST = 0;
        #2;
        nRST = 1;
    endtask

    // one DEPTH=4 cycle: inputs at negedge, registered results 1 after posedge
    task automatic cyc4(input bit ihit, input bit deq, input bit redir, input logic [31:0] rpc,
                        input bit halt);
        @(negedge CLK);
        f4.ihit = ihit; f4.deq = deq; f4.redirect = redir; f4.redirect_pc = rpc; f4.halt = halt;
        f4.imemload = redir ? 32'hDEAD_BEEF : word(f4.imemaddr);
        #1;
    endtask

    task automatic edge_wait();
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        bit          pre_reset;
        bit          ihit;
        bit          deq;
        bit          exp_ren;
        int          exp_count;
        bit          exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(bit r, bit ih, bit dq, bit ren, int c, bit v,
                                logic [31:0] p, logic [31:0] a);
        vec_t x;
        x.pre_reset = r; x.ihit = ih; x.deq = dq; x.exp_ren = ren;
        x.exp_count = c; x.exp_valid = v; x.exp_pc = p; x.exp_addr = a;
        return x;
    endfunction

    // DEPTH=2 reference model
    int unsigned mq[$];
    logic [31:0] mpc;

    initial begin
        // fill: continuous ihit until full, then ihit+deq streaming
        vecs[0]  = mk(1, 1, 0, 1, 1, 1, 32'h0, 32'h4);
        vecs[1]  = mk(0, 1, 0, 1, 2, 1, 32'h0, 32'h8);
        vecs[2]  = mk(0, 1, 0, 1, 3, 1, 32'h0, 32'hC);
        vecs[3]  = mk(0, 1, 0, 1, 4, 1, 32'h0, 32'h10);
        vecs[4]  = mk(0, 1, 0, 0, 4, 1, 32'h0, 32'h10);
        vecs[5]  = mk(0, 1, 0, 0, 4, 1, 32'h0, 32'h10);
        vecs[6]  = mk(1, 1, 1, 1, 1, 1, 32'h0, 32'h4);
        vecs[7]  = mk(0, 1, 1, 1, 1, 1, 32'h4, 32'h8);
        vecs[8]  = mk(0, 1, 1, 1, 1, 1, 32'h8, 32'hC);
        vecs[9]  = mk(0, 1, 1, 1, 1, 1, 32'hC, 32'h10);
        vecs[10] = mk(0, 1, 1, 1, 1, 1, 32'h10, 32'h14);
        vecs[11] = mk(0, 1, 1, 1, 1, 1, 32'h14, 32'h18);

        idle_inputs();
        nRST = 0;
        #3;
        chk("rst_count", 32'(f4.count), 32'd0);
        chk("rst_valid", 32'(f4.inst_valid), 32'd0);
        chk("rst_addr", f4.imemaddr, 32'h0);
        chk("rst_ren", 32'(f4.imemREN), 32'd1);
        nRST = 1;

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].pre_reset) apply_reset();
            cyc4(vecs[i].ihit, vecs[i].deq, 0, 0, 0);
            chk($sformatf("v%0d_ren", i), 32'(f4.imemREN), 32'(vecs[i].exp_ren));
            edge_wait();
            chk($sformatf("v%0d_count", i), 32'(f4.count), 32'(vecs[i].exp_count));
            chk($sformatf("v%0d_valid", i), 32'(f4.inst_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("v%0d_addr", i), f4.imemaddr, vecs[i].exp_addr);
            if (vecs[i].exp_valid) begin
                chk($sformatf("v%0d_pc", i), f4.inst_pc, vecs[i].exp_pc);
                chk($sformatf("v%0d_inst", i), f4.inst, word(vecs[i].exp_pc));
                chk($sformatf("v%0d_npc", i), f4.inst_npc, vecs[i].exp_pc + 32'd4);
            end
        end

        // redirect with count=3 and a same-cycle ihit
        apply_reset();
        for (int i = 0; i < 3; i++) begin cyc4(1, 0, 0, 0, 0); edge_wait(); end
        chk("rd_pre_count", 32'(f4.count), 32'd3);
        cyc4(1, 1, 1, 32'h103, 0);
        chk("rd_ren", 32'(f4.imemREN), 32'd0);
        edge_wait();
        chk("rd_count", 32'(f4.count), 32'd0);
        chk("rd_valid", 32'(f4.inst_valid), 32'd0);
        chk("rd_addr", f4.imemaddr, 32'h100);
        cyc4(1, 0, 0, 0, 0);
        chk("rd_ren2", 32'(f4.imemREN), 32'd1);
        edge_wait();
        chk("rd_count2", 32'(f4.count), 32'd1);
        chk("rd_pc2", f4.inst_pc, 32'h100);
        chk("rd_inst2", f4.inst, word(32'h100));

        // halt pulse with count=2, drain, redirect while halted, then reset
        apply_reset();
        for (int i = 0; i < 2; i++) begin cyc4(1, 0, 0, 0, 0); edge_wait(); end
        cyc4(1, 0, 0, 0, 1);
        chk("h_ren_same", 32'(f4.imemREN), 32'd0);
        edge_wait();
        chk("h_count", 32'(f4.count), 32'd2);
        cyc4(1, 1, 0, 0, 0);
        chk("h_ren_after", 32'(f4.imemREN), 32'd0);
        edge_wait();
        chk("h_count1", 32'(f4.count), 32'd1);
        chk("h_pc1", f4.inst_pc, 32'h4);
        cyc4(1, 1, 0, 0, 0);
        edge_wait();
        chk("h_valid0", 32'(f4.inst_valid), 32'd0);
        cyc4(1, 1, 0, 0, 0);
        edge_wait();
        chk("h_count0", 32'(f4.count), 32'd0);
        chk("h_addr_hold", f4.imemaddr, 32'h8);
        cyc4(1, 0, 1, 32'h202, 0);
        edge_wait();
        cyc4(1, 0, 0, 0, 0);
        chk("h_rd_addr", f4.imemaddr, 32'h200);
        chk("h_rd_ren", 32'(f4.imemREN), 32'd0);
        edge_wait();
        chk("h_rd_count", 32'(f4.count), 32'd0);
        apply_reset();
        #1;
        chk("h_rst_ren", 32'(f4.imemREN), 32'd1);
        chk("h_rst_addr", f4.imemaddr, 32'h0);

        // asynchronous reset mid-cycle with count=3
        for (int i = 0; i < 3; i++) begin cyc4(1, 0, 0, 0, 0); edge_wait(); end
        chk("ar_pre_count", 32'(f4.count), 32'd3);
        @(negedge CLK);
        idle_inputs();
        #1;
        nRST = 0;
        #1;
        chk("ar_count", 32'(f4.count), 32'd0);
        chk("ar_valid", 32'(f4.inst_valid), 32'd0);
        chk("ar_addr", f4.imemaddr, 32'h0);
        nRST = 1;

        // DEPTH=2 random traffic against a queue model
        apply_reset();
        mq.delete();
        mpc = 32'h0;
        for (int c = 0; c < 200; c++) begin
            bit ih, dq, rd, exp_ren;
            logic [31:0] rpc;
            ih  = ($urandom_range(0, 3) != 0);
            dq  = ($urandom_range(0, 2) != 0);
            rd  = ($urandom_range(0, 15) == 0);
            rpc = $urandom;
            @(negedge CLK);
            f2.ihit = ih; f2.deq = dq; f2.redirect = rd; f2.redirect_pc = rpc;
            f2.imemload = word(mpc);
            #1;
            exp_ren = !rd && (mq.size() < 2);
            chk("r_ren", 32'(f2.imemREN), 32'(exp_ren));
            chk("r_addr", f2.imemaddr, mpc);
            chk("r_valid", 32'(f2.inst_valid), 32'(mq.size() > 0));
            if (mq.size() > 0) begin
                chk("r_pc", f2.inst_pc, mq[0]);
                chk("r_inst", f2.inst, word(mq[0]));
            end
            @(posedge CLK);
            if (rd) begin
                mq.delete();
                mpc = rpc & ~32'h3;
            end else begin
                if (dq && mq.size() > 0) void'(mq.pop_front());
                if (exp_ren && ih) begin
                    mq.push_back(mpc);
                    mpc = mpc + 32'd4;
                end
            end
            #1;
            chk("r_count", 32'(f2.count), 32'(mq.size()));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end
endmodule
